// File: rtl/pe_pkg.sv
// Shared types and constants for the PE data-memory sequencer.
package pe_pkg;
    localparam int         DM_ADDR_WIDTH = 8;
    localparam int         INST_WIDTH    = 32;
    localparam logic [2:0] OP_MAX        = 3'b111;

    typedef enum logic [1:0] {
        CMD_LOAD      = 2'b00,
        CMD_SHIFT_IN  = 2'b01,
        CMD_EXEC      = 2'b10,
        CMD_SHIFT_OUT = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_SHIFT_IN, ST_EXEC, ST_DRAIN, ST_SHIFT_OUT, ST_FLUSH
    } state_e;

    typedef logic [DM_ADDR_WIDTH-1:0] len_t;

    // Remaining-count decrement that sticks at zero.
    function automatic len_t dec_sat(len_t v);
        return (v == '0) ? '0 : v - len_t'(1);
    endfunction
endpackage

// File: rtl/dm_seq_ctrl_if.sv
// Host command/data handshakes plus the data-memory strobe bundle.
interface dm_seq_ctrl_if #(
    parameter int INST_WIDTH = pe_pkg::INST_WIDTH
);
    pe_pkg::cmd_e          cmd;
    pe_pkg::len_t          cmd_len;
    logic                  cmd_valid, cmd_ready;
    logic                  in_valid, in_ready;
    logic                  tx_valid, tx_ready;
    logic [INST_WIDTH-1:0] inst_in, dm_inst;
    logic                  inst_valid, inst_ready;
    logic                  dm_wea, dm_web, dm_wec, dm_wed, dm_rea, dm_rec;
    logic                  out_valid, busy, done, err;

    modport master (
        output cmd, cmd_len, cmd_valid, in_valid, tx_valid, inst_in, inst_valid,
        input  cmd_ready, in_ready, tx_ready, inst_ready, dm_inst,
               dm_wea, dm_web, dm_wec, dm_wed, dm_rea, dm_rec, out_valid, busy, done, err
    );

    modport slave (
        input  cmd, cmd_len, cmd_valid, in_valid, tx_valid, inst_in, inst_valid,
        output cmd_ready, in_ready, tx_ready, inst_ready, dm_inst,
               dm_wea, dm_web, dm_wec, dm_wed, dm_rea, dm_rec, out_valid, busy, done, err
    );
endinterface

// File: rtl/wb_delay_line.sv
// Fixed-depth 1-bit strobe delay. empty is high when no set bit sits behind the
// output stage, i.e. the current output (if any) is the last one pending.
module wb_delay_line #(
    parameter int DEPTH = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic empty
);
    logic [DEPTH-1:0] sr_q, sr_d;

    if (DEPTH == 1) begin : g_d1
        always_comb begin
            sr_d  = din;
            empty = 1'b1;
        end
    end else begin : g_dn
        always_comb begin
            sr_d  = {sr_q[DEPTH-2:0], din};
            empty = (sr_q[DEPTH-2:0] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

    assign dout = sr_q[DEPTH-1];
endmodule

// File: rtl/dm_seq_ctrl.sv
// Turns host commands into data-memory strobe sequences and arbitrates the
// shared write-data bus between burst writes and TX beats.
module dm_seq_ctrl #(
    parameter int WB_LAT     = 6,
    parameter int RD_LAT     = 3,
    parameter int INST_WIDTH = pe_pkg::INST_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    dm_seq_ctrl_if.slave bus
);
    import pe_pkg::*;

    state_e state_q, state_d;
    len_t   rem_q, rem_d;
    logic   done_q, done_d, err_q, err_d, wec_q, wec_d;

    logic                  cmd_rdy, tx_rdy, in_rdy, inst_rdy;
    logic                  wea, web, wec, rea, rec;
    logic                  wb_out, wb_empty, rd_out, rd_empty;
    logic [INST_WIDTH-1:0] dm_inst_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wec_q   <= wec_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        err_d     = err_q;
        in_rdy    = 1'b0;
        inst_rdy  = 1'b0;
        wea       = 1'b0;
        web       = 1'b0;
        rea       = 1'b0;
        rec       = 1'b0;
        dm_inst_c = '0;
        // Bursts own the write-data bus; a TX beat also masks cmd_ready for
        // one extra cycle so a TX burst is never split by a new command.
        tx_rdy  = ~rst & (state_q inside {ST_IDLE, ST_EXEC, ST_DRAIN, ST_SHIFT_OUT});
        wec     = tx_rdy & bus.tx_valid;
        cmd_rdy = ~rst & (state_q == ST_IDLE) & ~wec & ~wec_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_rdy) begin
                    rem_d = bus.cmd_len;
                    if (bus.cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        case (bus.cmd)
                            CMD_LOAD:      state_d = ST_LOAD;
                            CMD_SHIFT_IN:  state_d = ST_SHIFT_IN;
                            CMD_EXEC:      state_d = ST_EXEC;
                            CMD_SHIFT_OUT: state_d = ST_SHIFT_OUT;
                            default:       state_d = ST_IDLE;
                        endcase
                    end
                end
            end
            ST_LOAD, ST_SHIFT_IN: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    wea   = (state_q == ST_LOAD);
                    web   = (state_q == ST_SHIFT_IN);
                    rem_d = dec_sat(rem_q);
                    if (rem_q == len_t'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    // Memory write address restarts on a gap: abort the burst.
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_EXEC: begin
                inst_rdy = 1'b1;
                if (bus.inst_valid) begin
                    rea       = 1'b1;
                    dm_inst_c = bus.inst_in;
                    rem_d     = dec_sat(rem_q);
                    if (rem_q == len_t'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wb_empty) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_SHIFT_OUT: begin
                rec   = 1'b1;
                rem_d = dec_sat(rem_q);
                if (rem_q == len_t'(1)) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (rd_empty) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst) begin
            in_rdy    = 1'b0;
            inst_rdy  = 1'b0;
            wea       = 1'b0;
            web       = 1'b0;
            rea       = 1'b0;
            rec       = 1'b0;
            dm_inst_c = '0;
        end
        wec_d = wec;
    end

    wb_delay_line #(.DEPTH(WB_LAT)) u_wb_dl (
        .clk(clk), .rst(rst), .din(rea), .dout(wb_out), .empty(wb_empty)
    );

    wb_delay_line #(.DEPTH(RD_LAT)) u_rd_dl (
        .clk(clk), .rst(rst), .din(rec), .dout(rd_out), .empty(rd_empty)
    );

    assign bus.cmd_ready  = cmd_rdy;
    assign bus.in_ready   = in_rdy;
    assign bus.tx_ready   = tx_rdy;
    assign bus.inst_ready = inst_rdy;
    assign bus.dm_inst    = dm_inst_c;
    assign bus.dm_wea     = wea;
    assign bus.dm_web     = web;
    assign bus.dm_wec     = wec;
    assign bus.dm_rea     = rea;
    assign bus.dm_rec     = rec;
    assign bus.dm_wed     = wb_out & ~rst & (state_q inside {ST_EXEC, ST_DRAIN});
    assign bus.out_valid  = rd_out & ~rst;
    assign bus.busy       = ~rst & (state_q != ST_IDLE);
    assign bus.done       = done_q & ~rst;
    assign bus.err        = err_q & ~rst;
endmodule
